// File: rtl/decode_pkg.sv
// Shared opcode, field-position and payload definitions for the pipelined decode stage.
package decode_pkg;

  localparam int unsigned PC_W      = 16;
  localparam int unsigned IR_W      = 16;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned IMM_W     = 8;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS1_LSB = 8;
  localparam int unsigned RS2_LSB = 12;
  localparam int unsigned IMM_LSB = 8;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OPC_W-1:0] OP_LW   = 4'h6;

  // Non-operand control fields carried through the output register
  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [REG_IDX_W-1:0] rd;
    logic [OPC_W-1:0]     opcode;
    logic                 load;
  } ctrl_t;

  // 4'h4..4'h7 form the I-type group; everything else decodes as R-type
  function automatic logic is_itype(input logic [OPC_W-1:0] op);
    return (op[3:2] == 2'b01);
  endfunction

  function automatic logic is_load(input logic [OPC_W-1:0] op);
    return (op == OP_LW);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side, write-back and execute-side signal bundle of the decode stage.
interface decode_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       ir;
  logic [15:0]       pc;
  logic              wb_en;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       pcout;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        rdout;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] imm;
  logic              is_load;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, ir, pc, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, pcout, a, b, rdout, opcode, imm, is_load, stall_cnt
  );

  modport slave (
    input  in_valid, ir, pc, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, pcout, a, b, rdout, opcode, imm, is_load, stall_cnt
  );
endinterface

// File: rtl/decode_regfile.sv
// Register file: two combinational read ports, one synchronous write port, r0 hard-wired to 0.
module decode_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ra1,
  input  logic [3:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd
);
  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  logic [DATA_W-1:0] mem [NREG];
  logic [IDX_W-1:0]  i1, i2, iw;

  // Indices wrap modulo NREG by dropping the upper field bits
  assign i1 = ra1[IDX_W-1:0];
  assign i2 = ra2[IDX_W-1:0];
  assign iw = wa[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
    end else if (we && (iw != '0)) begin
      mem[iw] <= wd;
    end
  end

  assign rd1 = (i1 == '0) ? '0 : mem[i1];
  assign rd2 = (i2 == '0) ? '0 : mem[i2];

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: field split, regfile read, immediate build, valid/ready output register,
// load-use stall and stall counter. Optional write-back bypass via `define DECODE_BYPASS_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  logic [REG_IDX_W-1:0] rs1, rs2, rd;
  logic [OPC_W-1:0]     opc;
  logic                 itype;
  logic [DATA_W-1:0]    rf_a, rf_b, byp_a, byp_b, op_b, imm_d;
  logic                 hazard, ready, fire;

  ctrl_t             ctrl_q;
  logic              valid_q;
  logic [DATA_W-1:0] a_q, b_q, imm_q;
  logic [CNT_W-1:0]  cnt_q;

  assign rs2   = bus.ir[RS2_LSB +: REG_IDX_W];
  assign rs1   = bus.ir[RS1_LSB +: REG_IDX_W];
  assign rd    = bus.ir[RD_LSB  +: REG_IDX_W];
  assign opc   = bus.ir[OPC_LSB +: OPC_W];
  assign itype = is_itype(opc);

  decode_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rf_a),
    .rd2 (rf_b),
    .we  (bus.wb_en),
    .wa  (bus.wb_addr),
    .wd  (bus.wb_data)
  );

  // Operand source selection for the fire cycle
  always_comb begin
    byp_a = rf_a;
    byp_b = rf_b;
`ifdef DECODE_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr == rs1) && (rs1 != '0)) byp_a = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr == rs2) && (rs2 != '0)) byp_b = bus.wb_data;
`endif
  end

  assign op_b  = itype ? '0 : byp_b;
  assign imm_d = itype ? DATA_W'($signed(bus.ir[IMM_LSB +: IMM_W])) : '0;

  // Load in the output register whose destination the incoming instruction reads
  assign hazard = bus.in_valid && valid_q && ctrl_q.load && (ctrl_q.rd != '0) &&
                  ((rs1 == ctrl_q.rd) || (!itype && (rs2 == ctrl_q.rd)));
  assign ready  = (!valid_q || bus.out_ready) && !hazard;
  assign fire   = bus.in_valid && ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
    end else if (fire) begin
      valid_q       <= 1'b1;
      ctrl_q.pc     <= bus.pc;
      ctrl_q.rd     <= rd;
      ctrl_q.opcode <= opc;
      ctrl_q.load   <= is_load(opc);
      a_q           <= byp_a;
      b_q           <= op_b;
      imm_q         <= imm_d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (hazard && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.pcout     = ctrl_q.pc;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.rdout     = ctrl_q.rd;
  assign bus.opcode    = ctrl_q.opcode;
  assign bus.imm       = imm_q;
  assign bus.is_load   = ctrl_q.load;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised pipelined decode stage for the 16-bit processor. It is the successor to the single-cycle decode cycle. It splits the instruction, reads a parametrised register file, and builds the immediate. The result is held in a valid/ready output register that feeds the execute stage. It adds backpressure, load-use hazard stalling, a stall counter and optional write-back bypass.

## Interface
- DATA_W, 16, register/data width (≥8)
- NREG, 16, register count (power of two, ≤16; rs/rd fields are 4 bits, upper indices ignored modulo NREG)
- CNT_W, 8, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  instruction available from fetch
- in_ready  out  1  stage accepts instruction this cycle
- ir  in  16  instruction: [15:12] rs2, [11:8] rs1, [7:4] rd, [3:0] opcode
- pc  in  16  PC of ir
- wb_en  in  1  register write enable (from write-back)
- wb_addr  in  4  write register
- wb_data  in  DATA_W  write value
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  execute accepts
- pcout  out  16  registered pc
- a, b  out  DATA_W  rs1 / rs2 operand (b = 0 for I-type)
- rdout  out  4  destination register
- opcode  out  4  registered opcode
- imm  out  DATA_W  sign-extended ir[15:8] for I-type, else 0
- is_load  out  1  registered load flag
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles

## Operation
- Opcodes are 4'h0–4'h3 (R-type) and 4'h4–4'h7 (I-type). The load opcode is 4'h6. Others decode as R-type.
- Register file: r0 reads 0, and writes to r0 are ignored. A write occurs at the clk edge when wb_en=1, independent of stall or handshake state.
- Fire = in_valid && in_ready. On fire, the output register captures all decoded fields and sets out_valid=1.
- If out_ready=1 and there is no fire, out_valid clears.
- in_ready = (!out_valid || out_ready) && !hazard.
- hazard = in_valid && out_valid && is_load && rdout≠0 && (rs1==rdout || (R-type && rs2==rdout)).
  - While hazard is high and out_ready=1, a bubble is inserted: out_valid→0 and ir is held upstream. The stall lasts exactly one cycle.
  - stall_cnt increments once per hazard cycle and saturates at all-ones.
- While out_valid=1 and out_ready=0, every output is held stable.
- Reset clears all registers, the register file and stall_cnt to 0, and sets out_valid=0.
- Reset is asynchronous, so an assertion mid-operation drops out_valid immediately.

## Timing
- Latency: out_valid rises one clk after fire.
- Throughput is 1 instruction/cycle with out_ready held high and no hazard.
- Operands are sampled at the fire edge.
- A write-back to the same register in the fire cycle follows the rule under Configuration.
- in_ready is combinational from in_valid, ir, out_valid and out_ready. No combinational path exists from wb_* to in_ready.
- Simultaneous fire and out_ready: the output register is replaced in the same cycle with no bubble.

## Configuration
- DECODE_BYPASS_EN defined: when wb_en && wb_addr==rsX && rsX≠0 in the fire cycle, the operand takes wb_data.
- DECODE_BYPASS_EN undefined: the operand takes the pre-write register value. Write-back must then be ≥1 cycle ahead, which the scheduler guarantees.

## Structure
- decode_pkg holds:
  - opcode localparams (OP_ADD=4'h0, OP_ADDI=4'h4, OP_LW=4'h6)
  - field bit-position constants
  - is_itype/is_load functions
- The sub-module decode_regfile has parameters DATA_W/NREG, two combinational read ports and one synchronous write port, with async active-low clear.
- Bypass muxing lives in decode_stage, not in the regfile.

## Test plan
- Reset: hold rst=0 → all outputs 0 and in_ready=1. Release, then read r5 → a=0.
- Basic decode:
  - Write r1=0x0011 and r2=0x0022.
  - Apply ir=16'h2160, pc=16'h0040 with in_valid=1.
  - Next cycle → out_valid=1, a=0x0011, b=0x0022, rdout=6, opcode=0, pcout=0x0040, imm=0.
- Bypass: r1=0x0011, and in the fire cycle wb_en=1, wb_addr=1, wb_data=0x00AB with ir=16'h2160 → a=0x00AB with the macro, a=0x0011 without it. The r1 write to 0x00AB lands in both builds.
- Backpressure: hold out_ready=0 after a fire → in_ready=0 and outputs unchanged for 5 cycles. Raise out_ready → the next instruction is delivered one cycle later.
- Load-use hazard: fire ir=16'h0136 (LW, rd=3), then ir=16'h2310 reading r3, with out_ready=1 → one bubble cycle, in_ready=0 for 1 cycle, stall_cnt=1, and the ADD appears 2 cycles after the LW. With rd=0 there is no stall.
- Immediate and async reset:
  - Apply ir=16'h8154 (ADDI, ir[15:8]=0x81), DATA_W=16 → imm=16'hFF81, b=0.
  - Assert rst mid-cycle while out_valid=1 → out_valid=0 before the next clk edge.
